// File: rtl/sound_output_stage.sv
// sound_output_stage: decimates SO1/SO2 to the codec rate, applies NR50 volume and buffers stereo pairs for AC97.
// Optional SOUND_OUTPUT_PREFILL_EN holds off pops until the FIFO first reaches half full.
module sound_output_stage #(
  parameter int SAMPLE_DIV = 95,
  parameter int FIFO_AW    = 3,
  parameter int SW         = 20
) (
  input  logic               I_CLK,
  input  logic               I_RESET_L,
  input  logic [SW-1:0]      I_SO1,
  input  logic [SW-1:0]      I_SO2,
  input  logic [7:0]         I_NR50,
  input  logic               I_SOUND_EN,
  input  logic               I_FRAME_REQ,
  output logic [SW-1:0]      O_LEFT,
  output logic [SW-1:0]      O_RIGHT,
  output logic               O_VALID,
  output logic [FIFO_AW:0]   O_LEVEL,
  output logic               O_UNDERRUN,
  output logic               O_OVERFLOW
);
  localparam int DEPTH = 1 << FIFO_AW;
  logic [15:0]        div_q;
  logic               tick;
  logic               s1_v_q, s2_v_q;
  logic [SW-1:0]      s1_l_q, s1_r_q, s2_l_q, s2_r_q;
  logic [2:0]         s1_vl_q, s1_vr_q;
  logic [SW+2:0]      l_prod, r_prod;
  logic [2*SW-1:0]    mem_q [DEPTH];
  logic [FIFO_AW:0]   wr_q, rd_q;
  logic               empty, full, pop, pop_ok, push_ok, pop_en;
  assign tick    = div_q == 16'(SAMPLE_DIV - 1);
  assign l_prod  = {3'b000, s1_l_q} * ((SW+3)'(s1_vl_q) + (SW+3)'(1));
  assign r_prod  = {3'b000, s1_r_q} * ((SW+3)'(s1_vr_q) + (SW+3)'(1));
  assign empty   = wr_q == rd_q;
  assign full    = (wr_q ^ rd_q) == {1'b1, {FIFO_AW{1'b0}}};
  assign pop     = I_FRAME_REQ & pop_en;
  assign pop_ok  = pop & ~empty;
  // a pop on a full FIFO frees the slot the simultaneous push lands in
  assign push_ok = s2_v_q & (~full | pop_ok);
  assign O_LEVEL = wr_q - rd_q;
`ifdef SOUND_OUTPUT_PREFILL_EN
  logic open_q;
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) open_q <= 1'b0;
    else if (pop && empty) open_q <= 1'b0;
    else if (O_LEVEL >= (FIFO_AW+1)'(DEPTH / 2)) open_q <= 1'b1;
  end
  assign pop_en = open_q;
`else
  assign pop_en = 1'b1;
`endif
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      div_q      <= '0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s1_l_q     <= '0;
      s1_r_q     <= '0;
      s1_vl_q    <= '0;
      s1_vr_q    <= '0;
      s2_l_q     <= '0;
      s2_r_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      O_LEFT     <= '0;
      O_RIGHT    <= '0;
      O_VALID    <= 1'b0;
      O_UNDERRUN <= 1'b0;
      O_OVERFLOW <= 1'b0;
    end else begin
      div_q  <= tick ? '0 : div_q + 16'd1;
      s1_v_q <= tick;
      s2_v_q <= s1_v_q;
      if (tick) begin
        s1_l_q  <= I_SOUND_EN ? I_SO2 : '0;
        s1_r_q  <= I_SOUND_EN ? I_SO1 : '0;
        s1_vl_q <= I_NR50[6:4];
        s1_vr_q <= I_NR50[2:0];
      end
      if (s1_v_q) begin
        s2_l_q <= l_prod[SW+2:3];
        s2_r_q <= r_prod[SW+2:3];
      end
      if (push_ok) wr_q <= wr_q + (FIFO_AW+1)'(1);
      if (pop_ok) begin
        rd_q    <= rd_q + (FIFO_AW+1)'(1);
        O_LEFT  <= mem_q[rd_q[FIFO_AW-1:0]][2*SW-1:SW];
        O_RIGHT <= mem_q[rd_q[FIFO_AW-1:0]][SW-1:0];
      end
      O_VALID <= pop;
      if (pop && empty) O_UNDERRUN <= 1'b1;
      if (s2_v_q && !push_ok) O_OVERFLOW <= 1'b1;
    end
  end
  always_ff @(posedge I_CLK) begin
    if (push_ok) mem_q[wr_q[FIFO_AW-1:0]] <= {s2_l_q, s2_r_q};
  end
endmodule

// File: tb/tb_sound_output_stage.sv
// tb_sound_output_stage: directed vector table plus hand sequences for latency, overflow, underrun and reset.
module tb_sound_output_stage;
  logic        I_CLK = 1'b0;
  logic        I_RESET_L = 1'b1;
  logic [19:0] I_SO1 = '0;
  logic [19:0] I_SO2 = '0;
  logic [7:0]  I_NR50 = 8'h77;
  logic        I_SOUND_EN = 1'b1;
  logic        I_FRAME_REQ = 1'b0;
  logic [19:0] O_LEFT, O_RIGHT;
  logic        O_VALID, O_UNDERRUN, O_OVERFLOW;
  logic [3:0]  O_LEVEL;
  int passed = 0;
  int total = 0;

  sound_output_stage dut (
    .I_CLK(I_CLK), .I_RESET_L(I_RESET_L), .I_SO1(I_SO1), .I_SO2(I_SO2),
    .I_NR50(I_NR50), .I_SOUND_EN(I_SOUND_EN), .I_FRAME_REQ(I_FRAME_REQ),
    .O_LEFT(O_LEFT), .O_RIGHT(O_RIGHT), .O_VALID(O_VALID), .O_LEVEL(O_LEVEL),
    .O_UNDERRUN(O_UNDERRUN), .O_OVERFLOW(O_OVERFLOW)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [19:0] so1;
    logic [19:0] so2;
    logic [7:0]  nr50;
    logic        en;
    logic [19:0] exp_l;
    logic [19:0] exp_r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    I_FRAME_REQ = 1'b0;
    @(negedge I_CLK);
    I_RESET_L = 1'b0;
    @(negedge I_CLK);
    I_RESET_L = 1'b1;
  endtask

  task automatic pulse_req();
    I_FRAME_REQ = 1'b1;
    @(negedge I_CLK);
    I_FRAME_REQ = 1'b0;
  endtask

  task automatic wait_level(input logic [3:0] target, input int budget, output int n);
    n = 0;
    while (O_LEVEL !== target && n < budget) begin
      @(negedge I_CLK);
      n++;
    end
  endtask

  vec_t vecs [6];
  int n;
  logic [3:0] lvl0;
  logic ovf0;

  initial begin
    vecs[0] = '{20'hFFFFF, 20'h00000, 8'h00, 1'b1, 20'h00000, 20'h1FFFF};
    vecs[1] = '{20'h00000, 20'h00800, 8'h33, 1'b1, 20'h00400, 20'h00000};
    vecs[2] = '{20'h00100, 20'h00200, 8'h77, 1'b1, 20'h00200, 20'h00100};
    vecs[3] = '{20'h12345, 20'h12345, 8'h77, 1'b0, 20'h00000, 20'h00000};
    vecs[4] = '{20'h12345, 20'hABCDE, 8'hDA, 1'b1, 20'h80DA6, 20'h06D39};
    vecs[5] = '{20'hFFFFF, 20'hFFFFF, 8'h88, 1'b1, 20'h1FFFF, 20'h1FFFF};

    #1 I_RESET_L = 1'b0;
    #1;
    chk("reset_left", O_LEFT, 0);
    chk("reset_right", O_RIGHT, 0);
    chk("reset_valid", O_VALID, 0);
    chk("reset_level", O_LEVEL, 0);
    chk("reset_flags", {O_UNDERRUN, O_OVERFLOW}, 0);

    for (int i = 0; i < 6; i++) begin
      I_SO1 = vecs[i].so1;
      I_SO2 = vecs[i].so2;
      I_NR50 = vecs[i].nr50;
      I_SOUND_EN = vecs[i].en;
      do_reset();
      wait_level(4'd1, 200, n);
      chk($sformatf("vec%0d_push", i), O_LEVEL, 1);
      pulse_req();
      chk($sformatf("vec%0d_valid", i), O_VALID, 1);
      chk($sformatf("vec%0d_left", i), O_LEFT, vecs[i].exp_l);
      chk($sformatf("vec%0d_right", i), O_RIGHT, vecs[i].exp_r);
    end

    // pop on the push edge of an empty FIFO: underrun, push still lands
    I_SO1 = 20'h00100; I_SO2 = 20'h00200; I_NR50 = 8'h77; I_SOUND_EN = 1'b1;
    do_reset();
    repeat (96) @(negedge I_CLK);
    chk("empty_sim_level_before", O_LEVEL, 0);
    pulse_req();
    chk("empty_sim_level", O_LEVEL, 1);
    chk("empty_sim_underrun", O_UNDERRUN, 1);
    chk("empty_sim_valid", O_VALID, 1);
    chk("empty_sim_right_hold", O_RIGHT, 0);
    pulse_req();
    chk("empty_sim_next_pop", O_RIGHT, 20'h00100);

    // overflow: nine captures into depth eight, distinct samples
    I_SO1 = 20'd1; I_SO2 = 20'h11;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      lvl0 = O_LEVEL;
      ovf0 = O_OVERFLOW;
      n = 0;
      while (O_LEVEL === lvl0 && O_OVERFLOW === ovf0 && n < 200) begin
        @(negedge I_CLK);
        n++;
      end
      I_SO1 = 20'(k + 1);
      I_SO2 = 20'(16'h10 + k + 1);
      if (k == 8) begin
        chk("ovf_level8", O_LEVEL, 8);
        chk("ovf_not_yet", O_OVERFLOW, 0);
      end
    end
    chk("ovf_level_after9", O_LEVEL, 8);
    chk("ovf_flag", O_OVERFLOW, 1);
    for (int k = 1; k <= 8; k++) begin
      pulse_req();
      chk($sformatf("ovf_pop%0d_right", k), O_RIGHT, k);
      chk($sformatf("ovf_pop%0d_left", k), O_LEFT, 32'h10 + k);
    end
    chk("ovf_ninth_absent", O_LEVEL, 0);
    chk("under_before", O_UNDERRUN, 0);
    pulse_req();
    chk("under_valid", O_VALID, 1);
    chk("under_right_hold", O_RIGHT, 8);
    chk("under_left_hold", O_LEFT, 20'h18);
    chk("under_flag", O_UNDERRUN, 1);
    chk("ovf_sticky", O_OVERFLOW, 1);

    // full FIFO: pop coincides with the ninth push
    I_SO1 = 20'h00055; I_SO2 = 20'h00066;
    do_reset();
    repeat (856) @(negedge I_CLK);
    chk("full_sim_level_before", O_LEVEL, 8);
    pulse_req();
    chk("full_sim_level", O_LEVEL, 8);
    chk("full_sim_no_ovf", O_OVERFLOW, 0);
    chk("full_sim_valid", O_VALID, 1);
    chk("full_sim_right", O_RIGHT, 20'h00055);

    // asynchronous reset between clock edges
    #3 I_RESET_L = 1'b0;
    #1;
    chk("async_left", O_LEFT, 0);
    chk("async_right", O_RIGHT, 0);
    chk("async_level", O_LEVEL, 0);
    chk("async_flags", {O_VALID, O_UNDERRUN, O_OVERFLOW}, 0);
    @(negedge I_CLK);
    I_RESET_L = 1'b1;
    wait_level(4'd1, 300, n);
    chk("latency_first", n, 97);
    repeat (94) @(negedge I_CLK);
    chk("latency_hold", O_LEVEL, 1);
    @(negedge I_CLK);
    chk("latency_second", O_LEVEL, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sound_output_stage.md
Name: sound_output_stage

Overview:
- Sits directly downstream of the sound controller's SO1/SO2 mix outputs and upstream of the AC97 link.
- Decimates the mixed SO1/SO2 streams to the codec sample rate and applies NR50 master volume (not applied anywhere upstream).
- Buffers stereo samples in a small FIFO; the AC97 slot logic pops one sample pair per frame request.
- Handles underrun and overflow deterministically.

Parameters:
- SAMPLE_DIV, 95: core-clock cycles per captured sample (4.194304 MHz / 95 ≈ 44.1 kHz); legal range 4..65535.
- FIFO_AW, 3: FIFO address width; depth = 2^FIFO_AW pairs.
- SW, 20: sample width, unsigned.

Ports:
- I_CLK  in  1  core clock.
- I_RESET_L  in  1  asynchronous active-low reset.
- I_SO1  in  SW  mixed SO1 sample from the sound controller (right).
- I_SO2  in  SW  mixed SO2 sample from the sound controller (left).
- I_NR50  in  8  NR50 value: [6:4] SO2 volume, [2:0] SO1 volume; bits 7 and 3 are ignored.
- I_SOUND_EN  in  1  NR52[7]; when 0 the block captures zero samples.
- I_FRAME_REQ  in  1  one-cycle pulse in the I_CLK domain requesting the next pair.
- O_LEFT  out  SW  scaled SO2 sample presented to AC97.
- O_RIGHT  out  SW  scaled SO1 sample presented to AC97.
- O_VALID  out  1  one-cycle pulse when O_LEFT/O_RIGHT update.
- O_LEVEL  out  FIFO_AW+1  current FIFO occupancy.
- O_UNDERRUN  out  1  sticky; set on a pop while empty; cleared only by reset.
- O_OVERFLOW  out  1  sticky; set on a push while full; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): all outputs 0; divider 0; FIFO empty, rd/wr pointers 0; pipeline valid bits 0.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - At count SAMPLE_DIV-1 the capture tick fires for one cycle.
  - Exactly one tick every SAMPLE_DIV cycles; the first tick falls SAMPLE_DIV cycles after reset release.
- Stage 1 (tick cycle +1):
  - Registers I_SO1/I_SO2, or zeros when I_SOUND_EN=0.
  - Also registers the NR50 volumes sampled on the same edge.
- Stage 2 (tick +2):
  - scaled = (sample × (vol+1)) >> 3.
  - The product is SW+3 bits, truncated after the shift to SW bits; no overflow is possible.
  - vol=7 gives unity; vol=0 gives sample/8.
- Push at stage 2 completion, i.e. the FIFO write occurs on the edge 2 cycles after the tick.
  - If full: the write is dropped (oldest data kept), O_OVERFLOW sets, pointers are unchanged.
- Pop on I_FRAME_REQ:
  - If not empty: O_LEFT/O_RIGHT load the head entry on the next edge, O_VALID=1 for that cycle, rd pointer increments.
  - If empty: O_LEFT/O_RIGHT hold their previous values, O_VALID still pulses, O_UNDERRUN sets.
- Simultaneous push and pop:
  - When not empty, both occur and O_LEVEL is unchanged.
  - When empty, the pop is an underrun (no fall-through) and the push proceeds; O_LEVEL becomes 1.
  - When full, the pop frees a slot first, so the push succeeds and O_OVERFLOW does not set.
- Pointers are FIFO_AW+1 bits with wrap bit; full = MSBs differ and the rest are equal; empty = equal.
  - O_LEVEL = wr−rd modulo 2^(FIFO_AW+1).
- Reset asserted mid-operation: FIFO contents are discarded and the pipeline is flushed; the next sample is captured only after a full SAMPLE_DIV period.
- I_NR50 and I_SOUND_EN changes take effect on the next capture tick only; samples already in the pipeline keep their volume.

Optional Feature:
- Macro: SOUND_OUTPUT_PREFILL_EN.
- When defined:
  - After reset, pops are ignored (no O_VALID, no underrun) until O_LEVEL first reaches 2^(FIFO_AW-1) (4 at default).
  - The prefill gate re-arms after any underrun.
  - O_LEFT/O_RIGHT stay 0 until then.
- When undefined: pops are serviced from reset as described above.

Test Plan:
- Divider/latency: SAMPLE_DIV=95, I_SO1=0x00100, I_SO2=0x00200, NR50=0x77, no pops → O_LEVEL goes 0→1 exactly 95+2 cycles after reset release, then increments every 95 cycles.
- Volume math: I_SO1=0xFFFFF, NR50=0x00 → stored right=0x1FFFF; NR50=0x33 with I_SO2=0x00800 → left=0x00400; NR50=0x77 → unity.
- Sound disable: I_SOUND_EN=0, I_SO1=I_SO2=0x12345 → popped pairs are 0/0.
- Overflow: no pops for 9 ticks (depth 8) → O_LEVEL=8, O_OVERFLOW=1; the first 8 captured pairs pop back in order and the 9th is absent.
- Underrun/hold: empty FIFO, last output 0x00400/0x00400, I_FRAME_REQ pulse → O_VALID=1, outputs unchanged, O_UNDERRUN=1; with SOUND_OUTPUT_PREFILL_EN defined → no O_VALID until level 4.
- Simultaneous events plus async reset:
  - FIFO full + pop and push on the same edge → level stays 8, no overflow.
  - Assert I_RESET_L=0 mid-divider count → all outputs 0 immediately, without waiting for a clock edge.
